// File: rtl/ef_i2c_cmd_arbiter.sv
// Two-requester arbiter in front of one I2C master core; owns the core per transaction.
// Optional build macro EF_I2C_ARB_PRIORITY_EN selects fixed r0 priority instead of round-robin.
module ef_i2c_cmd_arbiter #(
  parameter int HOLD_TIMEOUT = 1024,
  parameter int TO_W         = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] r0_cmd_data,
  input  logic        r0_cmd_valid,
  output logic        r0_cmd_ready,
  input  logic [7:0]  r0_wr_data,
  input  logic        r0_wr_last,
  input  logic        r0_wr_valid,
  output logic        r0_wr_ready,
  output logic [7:0]  r0_rd_data,
  output logic        r0_rd_last,
  output logic        r0_rd_valid,
  input  logic        r0_rd_ready,
  input  logic [11:0] r1_cmd_data,
  input  logic        r1_cmd_valid,
  output logic        r1_cmd_ready,
  input  logic [7:0]  r1_wr_data,
  input  logic        r1_wr_last,
  input  logic        r1_wr_valid,
  output logic        r1_wr_ready,
  output logic [7:0]  r1_rd_data,
  output logic        r1_rd_last,
  output logic        r1_rd_valid,
  input  logic        r1_rd_ready,
  output logic [11:0] m_cmd_data,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic [7:0]  m_wr_data,
  output logic        m_wr_last,
  output logic        m_wr_valid,
  input  logic        m_wr_ready,
  input  logic [7:0]  m_rd_data,
  input  logic        m_rd_last,
  input  logic        m_rd_valid,
  output logic        m_rd_ready,
  input  logic        m_busy,
  output logic [1:0]  grant,
  output logic        timeout_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_ABORT,
    S_RELEASE
  } state_t;

  localparam logic            WD_EN  = (HOLD_TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_MAX = TO_W'(HOLD_TIMEOUT);
  localparam logic [11:0]     STOP_CMD = 12'h800;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            pick;
  logic            rel_done;

  logic [11:0] o_cmd_data;
  logic        o_cmd_valid;
  logic [7:0]  o_wr_data;
  logic        o_wr_last;
  logic        o_wr_valid;
  logic        o_rd_ready;

  logic        o_cmd_ready;
  logic        o_wr_ready;
  logic [7:0]  o_rd_data;
  logic        o_rd_last;
  logic        o_rd_valid;

  logic            cmd_hs, wr_hs, stop_hs;
  logic            activity, wd_hit;
  logic [TO_W-1:0] cnt_inc;

  assign o_cmd_data  = owner_q ? r1_cmd_data  : r0_cmd_data;
  assign o_cmd_valid = owner_q ? r1_cmd_valid : r0_cmd_valid;
  assign o_wr_data   = owner_q ? r1_wr_data   : r0_wr_data;
  assign o_wr_last   = owner_q ? r1_wr_last   : r0_wr_last;
  assign o_wr_valid  = owner_q ? r1_wr_valid  : r0_wr_valid;
  assign o_rd_ready  = owner_q ? r1_rd_ready  : r0_rd_ready;

  assign cmd_hs   = (state_q == S_OWN) && o_cmd_valid && m_cmd_ready;
  assign wr_hs    = (state_q == S_OWN) && o_wr_valid && m_wr_ready;
  assign stop_hs  = cmd_hs && o_cmd_data[11];
  assign activity = cmd_hs || wr_hs || m_busy;
  assign cnt_inc  = cnt_q + 1'b1;
  // expiry is judged on the would-be count, so a stop handshake
  // in the same cycle clears it and wins the race
  assign wd_hit   = WD_EN && !activity && (cnt_inc == WD_MAX);
  assign rel_done = (state_q == S_RELEASE) && !m_busy && !m_rd_valid;

  assign grant = (state_q == S_IDLE) ? 2'b00 :
                 (owner_q ? 2'b10 : 2'b01);
  assign timeout_pulse = pulse_q;

`ifdef EF_I2C_ARB_PRIORITY_EN
  assign pick = !r0_cmd_valid;
`else
  logic last_q;

  // remember who held the core last so ties alternate
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (rel_done) begin
      last_q <= owner_q;
    end
  end

  assign pick = (r0_cmd_valid && r1_cmd_valid) ? ~last_q : !r0_cmd_valid;
`endif

  // state, owner, watchdog counter and pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // next-state, arbitration and watchdog counting
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (r0_cmd_valid || r1_cmd_valid) begin
          owner_d = pick;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (stop_hs) begin
          state_d = S_RELEASE;
        end else if (wd_hit) begin
          state_d = S_ABORT;
        end else if (WD_EN && !activity) begin
          cnt_d = cnt_inc;
        end
      end
      S_ABORT: begin
        if (m_cmd_ready) begin
          pulse_d = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (rel_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // stream muxing between the owner and the core
  always_comb begin
    m_cmd_data  = '0;
    m_cmd_valid = 1'b0;
    m_wr_data   = '0;
    m_wr_last   = 1'b0;
    m_wr_valid  = 1'b0;
    m_rd_ready  = 1'b0;
    o_cmd_ready = 1'b0;
    o_wr_ready  = 1'b0;
    o_rd_data   = '0;
    o_rd_last   = 1'b0;
    o_rd_valid  = 1'b0;
    unique case (state_q)
      S_OWN: begin
        m_cmd_data  = o_cmd_data;
        m_cmd_valid = o_cmd_valid;
        o_cmd_ready = m_cmd_ready;
        m_wr_data   = o_wr_data;
        m_wr_last   = o_wr_last;
        m_wr_valid  = o_wr_valid;
        o_wr_ready  = m_wr_ready;
        o_rd_data   = m_rd_data;
        o_rd_last   = m_rd_last;
        o_rd_valid  = m_rd_valid;
        m_rd_ready  = o_rd_ready;
      end
      S_ABORT: begin
        m_cmd_data  = STOP_CMD;
        m_cmd_valid = 1'b1;
        m_rd_ready  = 1'b1;
      end
      S_RELEASE: begin
        o_rd_data   = m_rd_data;
        o_rd_last   = m_rd_last;
        o_rd_valid  = m_rd_valid;
        m_rd_ready  = o_rd_ready;
      end
      default: ;
    endcase
  end

  assign r0_cmd_ready = o_cmd_ready && !owner_q;
  assign r0_wr_ready  = o_wr_ready  && !owner_q;
  assign r0_rd_valid  = o_rd_valid  && !owner_q;
  assign r0_rd_last   = o_rd_last   && !owner_q;
  assign r0_rd_data   = owner_q ? 8'h00 : o_rd_data;

  assign r1_cmd_ready = o_cmd_ready && owner_q;
  assign r1_wr_ready  = o_wr_ready  && owner_q;
  assign r1_rd_valid  = o_rd_valid  && owner_q;
  assign r1_rd_last   = o_rd_last   && owner_q;
  assign r1_rd_data   = owner_q ? o_rd_data : 8'h00;

endmodule

// File: tb/tb_ef_i2c_cmd_arbiter.sv
// Directed self-checking bench for ef_i2c_cmd_arbiter.
// Runs the arbiter with an 8-cycle hold timeout.
module tb_ef_i2c_cmd_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] r0_cmd_data, r1_cmd_data;
  logic        r0_cmd_valid, r1_cmd_valid;
  logic        r0_cmd_ready, r1_cmd_ready;
  logic [7:0]  r0_wr_data, r1_wr_data;
  logic        r0_wr_last, r1_wr_last;
  logic        r0_wr_valid, r1_wr_valid;
  logic        r0_wr_ready, r1_wr_ready;
  logic [7:0]  r0_rd_data, r1_rd_data;
  logic        r0_rd_last, r1_rd_last;
  logic        r0_rd_valid, r1_rd_valid;
  logic        r0_rd_ready, r1_rd_ready;
  logic [11:0] m_cmd_data;
  logic        m_cmd_valid, m_cmd_ready;
  logic [7:0]  m_wr_data;
  logic        m_wr_last, m_wr_valid, m_wr_ready;
  logic [7:0]  m_rd_data;
  logic        m_rd_last, m_rd_valid, m_rd_ready;
  logic        m_busy;
  logic [1:0]  grant;
  logic        timeout_pulse;

  int errors = 0;
  int checks = 0;

  ef_i2c_cmd_arbiter #(
    .HOLD_TIMEOUT(8),
    .TO_W(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_cmd_data(r0_cmd_data), .r0_cmd_valid(r0_cmd_valid),
    .r0_cmd_ready(r0_cmd_ready),
    .r0_wr_data(r0_wr_data), .r0_wr_last(r0_wr_last),
    .r0_wr_valid(r0_wr_valid), .r0_wr_ready(r0_wr_ready),
    .r0_rd_data(r0_rd_data), .r0_rd_last(r0_rd_last),
    .r0_rd_valid(r0_rd_valid), .r0_rd_ready(r0_rd_ready),
    .r1_cmd_data(r1_cmd_data), .r1_cmd_valid(r1_cmd_valid),
    .r1_cmd_ready(r1_cmd_ready),
    .r1_wr_data(r1_wr_data), .r1_wr_last(r1_wr_last),
    .r1_wr_valid(r1_wr_valid), .r1_wr_ready(r1_wr_ready),
    .r1_rd_data(r1_rd_data), .r1_rd_last(r1_rd_last),
    .r1_rd_valid(r1_rd_valid), .r1_rd_ready(r1_rd_ready),
    .m_cmd_data(m_cmd_data), .m_cmd_valid(m_cmd_valid),
    .m_cmd_ready(m_cmd_ready),
    .m_wr_data(m_wr_data), .m_wr_last(m_wr_last),
    .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
    .m_rd_data(m_rd_data), .m_rd_last(m_rd_last),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
    .m_busy(m_busy),
    .grant(grant),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    r0_cmd_data = '0; r0_cmd_valid = 0; r0_wr_data = '0;
    r0_wr_last = 0; r0_wr_valid = 0; r0_rd_ready = 0;
    r1_cmd_data = '0; r1_cmd_valid = 0; r1_wr_data = '0;
    r1_wr_last = 0; r1_wr_valid = 0; r1_rd_ready = 0;
    m_cmd_ready = 0; m_wr_ready = 0; m_rd_data = '0;
    m_rd_last = 0; m_rd_valid = 0; m_busy = 0;
    tick;
    tick;
    rst_i = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_m_cmd_data", m_cmd_data, 0);
    chk("rst_m_rd_ready", m_rd_ready, 0);
    chk("rst_pulse", timeout_pulse, 0);

    // single requester write transaction
    m_cmd_ready = 1; m_wr_ready = 1;
    r0_cmd_data = 12'h2A5; r0_cmd_valid = 1;
    #1;
    chk("idle_grant", grant, 0);
    chk("idle_r0_cmd_ready", r0_cmd_ready, 0);
    chk("idle_m_cmd_valid", m_cmd_valid, 0);
    tick;
    chk("t1_grant", grant, 2'b01);
    chk("t1_m_cmd_valid", m_cmd_valid, 1);
    chk("t1_m_cmd_data", m_cmd_data, 12'h2A5);
    chk("t1_r0_cmd_ready", r0_cmd_ready, 1);
    chk("t1_r1_cmd_ready", r1_cmd_ready, 0);
    tick;
    r0_cmd_valid = 0; r0_wr_valid = 1; r0_wr_data = 8'h5A;
    r0_wr_last = 0; m_busy = 1;
    #1;
    chk("t1_wr0_valid", m_wr_valid, 1);
    chk("t1_wr0_data", m_wr_data, 8'h5A);
    chk("t1_wr0_ready", r0_wr_ready, 1);
    chk("t1_wr0_cmd_valid", m_cmd_valid, 0);
    tick;
    r0_wr_data = 8'hC3; r0_wr_last = 1;
    #1;
    chk("t1_wr1_data", m_wr_data, 8'hC3);
    chk("t1_wr1_last", m_wr_last, 1);
    tick;
    r0_wr_valid = 0; r0_wr_last = 0;
    r0_cmd_data = 12'h800; r0_cmd_valid = 1;
    #1;
    chk("t1_stop_data", m_cmd_data, 12'h800);
    chk("t1_stop_valid", m_cmd_valid, 1);
    tick;
    r0_cmd_valid = 0;
    #1;
    chk("t1_rel_grant", grant, 2'b01);
    chk("t1_rel_cmd_valid", m_cmd_valid, 0);
    tick;
    chk("t1_rel_busy_grant", grant, 2'b01);
    m_busy = 0;
    tick;
    chk("t1_done_grant", grant, 0);

    // contention right after reset: r0 first, then r1
    rst_i = 1;
    tick;
    rst_i = 0;
    r0_cmd_data = 12'h8A5; r0_cmd_valid = 1;
    r1_cmd_data = 12'h8B3; r1_cmd_valid = 1;
    #1;
    chk("rr_idle_grant", grant, 0);
    tick;
    chk("rr_first_r0", grant, 2'b01);
    chk("rr_first_data", m_cmd_data, 12'h8A5);
    chk("rr_r1_blocked", r1_cmd_ready, 0);
    tick;
    r0_cmd_valid = 0;
    #1;
    chk("rr_rel_grant", grant, 2'b01);
    chk("rr_rel_r1_ready", r1_cmd_ready, 0);
    tick;
    chk("rr_idle_gap", grant, 0);
    tick;
    chk("rr_then_r1", grant, 2'b10);
    chk("rr_r1_data", m_cmd_data, 12'h8B3);
    chk("rr_r1_ready", r1_cmd_ready, 1);
    chk("rr_r0_ready", r0_cmd_ready, 0);
    tick;
    r1_cmd_valid = 0;
    tick;
    r0_cmd_valid = 1; r1_cmd_valid = 1;
    #1;
    chk("rr2_idle_grant", grant, 0);
    tick;
    chk("rr2_r0_after_r1", grant, 2'b01);
    tick;
    r0_cmd_valid = 0;
    tick;
    tick;
    chk("rr2_r1_next", grant, 2'b10);
    tick;
    r1_cmd_valid = 0;
    tick;
    chk("rr2_done", grant, 0);

    // r1 read of three bytes plus stop
    r1_cmd_data = 12'h9A5; r1_cmd_valid = 1; r1_rd_ready = 1;
    #1;
    tick;
    chk("rd_grant", grant, 2'b10);
    chk("rd_cmd_data", m_cmd_data, 12'h9A5);
    m_busy = 1;
    tick;
    r1_cmd_valid = 0; m_rd_valid = 1; m_rd_data = 8'h11;
    #1;
    chk("rd_b0_valid", r1_rd_valid, 1);
    chk("rd_b0_data", r1_rd_data, 8'h11);
    chk("rd_b0_ready", m_rd_ready, 1);
    chk("rd_b0_r0_valid", r0_rd_valid, 0);
    chk("rd_b0_grant", grant, 2'b10);
    tick;
    m_rd_data = 8'h22;
    #1;
    chk("rd_b1_data", r1_rd_data, 8'h22);
    chk("rd_b1_r0_valid", r0_rd_valid, 0);
    tick;
    m_rd_data = 8'h33; m_rd_last = 1;
    #1;
    chk("rd_b2_data", r1_rd_data, 8'h33);
    chk("rd_b2_last", r1_rd_last, 1);
    chk("rd_b2_r0_valid", r0_rd_valid, 0);
    tick;
    m_rd_valid = 0; m_rd_last = 0; m_busy = 0;
    #1;
    chk("rd_hold_grant", grant, 2'b10);
    tick;
    chk("rd_done_grant", grant, 0);

    // watchdog: r0 stalls after start+write, r1 waiting
    r0_cmd_data = 12'h2A5; r0_cmd_valid = 1;
    r1_cmd_data = 12'h8B3; r1_cmd_valid = 1;
    m_cmd_ready = 1;
    #1;
    tick;
    chk("wd_grant", grant, 2'b01);
    tick;
    r0_cmd_valid = 0; m_cmd_ready = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("wd_wait_grant", grant, 2'b01);
      chk("wd_wait_cmd_valid", m_cmd_valid, 0);
      chk("wd_wait_pulse", timeout_pulse, 0);
      tick;
    end
    r0_wr_valid = 1;
    #1;
    chk("wd_abort_valid", m_cmd_valid, 1);
    chk("wd_abort_data", m_cmd_data, 12'h800);
    chk("wd_abort_wr_valid", m_wr_valid, 0);
    chk("wd_abort_wr_ready", r0_wr_ready, 0);
    chk("wd_abort_cmd_ready", r0_cmd_ready, 0);
    chk("wd_abort_rd_ready", m_rd_ready, 1);
    chk("wd_abort_pulse", timeout_pulse, 0);
    tick;
    chk("wd_abort_hold", m_cmd_valid, 1);
    m_cmd_ready = 1;
    tick;
    r0_wr_valid = 0;
    #1;
    chk("wd_pulse", timeout_pulse, 1);
    chk("wd_rel_cmd_valid", m_cmd_valid, 0);
    tick;
    chk("wd_pulse_end", timeout_pulse, 0);
    chk("wd_idle_grant", grant, 0);
    tick;
    chk("wd_r1_next", grant, 2'b10);
    tick;
    r1_cmd_valid = 0;
    tick;

    // stop handshake on the expiry cycle
    r0_cmd_data = 12'h2A5; r0_cmd_valid = 1;
    #1;
    tick;
    tick;
    r0_cmd_valid = 0;
    repeat (7) tick;
    r0_cmd_data = 12'h800; r0_cmd_valid = 1;
    #1;
    chk("race_own_grant", grant, 2'b01);
    chk("race_cmd_ready", r0_cmd_ready, 1);
    tick;
    r0_cmd_valid = 0;
    #1;
    chk("race_no_abort", m_cmd_valid, 0);
    chk("race_no_pulse", timeout_pulse, 0);
    chk("race_rel_grant", grant, 2'b01);
    tick;
    chk("race_idle_grant", grant, 0);
    chk("race_idle_pulse", timeout_pulse, 0);

    // reset in the middle of an owned transaction
    r0_cmd_data = 12'h2A5; r0_cmd_valid = 1;
    #1;
    tick;
    tick;
    r0_cmd_valid = 0; m_cmd_ready = 0;
    #1;
    chk("mid_own_grant", grant, 2'b01);
    rst_i = 1;
    tick;
    rst_i = 0;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_cmd_valid", m_cmd_valid, 0);
    chk("mid_rst_cmd_data", m_cmd_data, 0);
    chk("mid_rst_cmd_ready", r0_cmd_ready, 0);
    chk("mid_rst_wr_ready", r0_wr_ready, 0);
    chk("mid_rst_wr_valid", m_wr_valid, 0);
    chk("mid_rst_rd_ready", m_rd_ready, 0);
    m_cmd_ready = 1;
    for (int i = 0; i < 12; i++) begin
      chk("mid_rst_no_stop", m_cmd_valid, 0);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
